// File: rtl/l15_transducer_arbiter.sv
// l15_transducer_arbiter
// Shares the transducer->L1.5 request channel between the IFU and the LSU.
// One transaction is in flight at a time; grants alternate round-robin when
// both requesters are waiting. Interrupt returns are acknowledged in any
// state without disturbing the transaction, and a lost response is turned
// into an error response after TIMEOUT_CYCLES cycles in WAIT_RESP.
module l15_transducer_arbiter #(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [3:0] INT_RET_TYPE   = 4'b0111
) (
    input  logic        clk,
    input  logic        nrst,

    input  logic        ifu_req_val,
    input  logic [39:0] ifu_req_addr,
    input  logic        lsu_req_val,
    input  logic [4:0]  lsu_req_rqtype,
    input  logic [2:0]  lsu_req_size,
    input  logic [39:0] lsu_req_addr,
    input  logic [63:0] lsu_req_data,

    output logic        ifu_req_ack,
    output logic        lsu_req_ack,
    output logic        ifu_resp_val,
    output logic        lsu_resp_val,
    output logic        resp_err,
    output logic [63:0] resp_data0,
    output logic [63:0] resp_data1,
    output logic        int_ret_pulse,

    output logic        transducer_l15_val,
    output logic [4:0]  transducer_l15_rqtype,
    output logic [2:0]  transducer_l15_size,
    output logic [39:0] transducer_l15_address,
    output logic [63:0] transducer_l15_data,
    output logic        transducer_l15_req_ack,

    input  logic        l15_transducer_ack,
    input  logic        l15_transducer_header_ack,
    input  logic        l15_transducer_val,
    input  logic [3:0]  l15_transducer_returntype,
    input  logic [63:0] l15_transducer_data_0,
    input  logic [63:0] l15_transducer_data_1
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam logic [4:0]  IFU_RQTYPE   = 5'b10000;
    localparam logic [2:0]  IFU_SIZE     = 3'b111;
    localparam logic [4:0]  LSU_STORE    = 5'b00001;
    localparam logic [3:0]  RET_LOAD     = 4'b0000;
    localparam logic [3:0]  RET_IFILL    = 4'b0001;
    localparam logic [3:0]  RET_STORE    = 4'b0100;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    // Header ack carries no information this block needs.
    logic unused_header_ack;
    assign unused_header_ack = l15_transducer_header_ack;

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      last_owner_q, last_owner_d;
    logic [15:0] cnt_q, cnt_d;

    logic        val_q, val_d;
    logic [4:0]  rqtype_q, rqtype_d;
    logic [2:0]  size_q, size_d;
    logic [39:0] addr_q, addr_d;
    logic [63:0] data_q, data_d;

    logic        ifu_req_ack_q, ifu_req_ack_d;
    logic        lsu_req_ack_q, lsu_req_ack_d;
    logic        ifu_resp_val_q, ifu_resp_val_d;
    logic        lsu_resp_val_q, lsu_resp_val_d;
    logic        resp_err_q, resp_err_d;
    logic [63:0] resp_data0_q, resp_data0_d;
    logic [63:0] resp_data1_q, resp_data1_d;
    logic        req_ack_q, req_ack_d;
    logic        int_pulse_q, int_pulse_d;

    logic        ret_seen;
    logic        ret_is_int;
    logic        grant_ifu;
    logic        grant_lsu;
    logic        delivering;
    logic [3:0]  expected_ret;

    // A held return is ignored while its acknowledge is on the wire, and the
    // IFU wins a tie only when the LSU was the last one served.
    always_comb begin
        ret_seen     = l15_transducer_val && !req_ack_q;
        ret_is_int   = (l15_transducer_returntype == INT_RET_TYPE);
        delivering   = ifu_resp_val_q || lsu_resp_val_q;
        grant_ifu    = ifu_req_val && (!lsu_req_val || (last_owner_q == OWN_LSU));
        grant_lsu    = lsu_req_val && !grant_ifu;
        expected_ret = RET_IFILL;
        if (owner_q == OWN_LSU) begin
            expected_ret = (rqtype_q == LSU_STORE) ? RET_STORE : RET_LOAD;
        end
    end

    // Next-state and output-register logic for the arbitration FSM.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_owner_d   = last_owner_q;
        cnt_d          = cnt_q;
        val_d          = val_q;
        rqtype_d       = rqtype_q;
        size_d         = size_q;
        addr_d         = addr_q;
        data_d         = data_q;
        ifu_req_ack_d  = 1'b0;
        lsu_req_ack_d  = 1'b0;
        ifu_resp_val_d = 1'b0;
        lsu_resp_val_d = 1'b0;
        resp_err_d     = 1'b0;
        resp_data0_d   = resp_data0_q;
        resp_data1_d   = resp_data1_q;
        req_ack_d      = 1'b0;
        int_pulse_d    = 1'b0;

        if (ret_seen && ret_is_int) begin
            req_ack_d   = 1'b1;
            int_pulse_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!delivering && grant_ifu) begin
                    rqtype_d     = IFU_RQTYPE;
                    size_d       = IFU_SIZE;
                    addr_d       = ifu_req_addr;
                    data_d       = 64'd0;
                    owner_d      = OWN_IFU;
                    last_owner_d = OWN_IFU;
                    val_d        = 1'b1;
                    state_d      = REQ;
                end else if (!delivering && grant_lsu) begin
                    rqtype_d     = lsu_req_rqtype;
                    size_d       = lsu_req_size;
                    addr_d       = lsu_req_addr;
                    data_d       = lsu_req_data;
                    owner_d      = OWN_LSU;
                    last_owner_d = OWN_LSU;
                    val_d        = 1'b1;
                    state_d      = REQ;
                end
            end

            REQ: begin
                if (l15_transducer_ack) begin
                    val_d   = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = WAIT_RESP;
                    if (owner_q == OWN_IFU) begin
                        ifu_req_ack_d = 1'b1;
                    end else begin
                        lsu_req_ack_d = 1'b1;
                    end
                end
            end

            WAIT_RESP: begin
                cnt_d = cnt_q + 16'd1;
                if (ret_seen && !ret_is_int) begin
                    resp_data0_d = l15_transducer_data_0;
                    resp_data1_d = l15_transducer_data_1;
                    req_ack_d    = 1'b1;
                    resp_err_d   = (l15_transducer_returntype != expected_ret);
                    state_d      = IDLE;
                    if (owner_q == OWN_IFU) begin
                        ifu_resp_val_d = 1'b1;
                    end else begin
                        lsu_resp_val_d = 1'b1;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    resp_data0_d = 64'd0;
                    resp_data1_d = 64'd0;
                    resp_err_d   = 1'b1;
                    state_d      = IDLE;
                    if (owner_q == OWN_IFU) begin
                        ifu_resp_val_d = 1'b1;
                    end else begin
                        lsu_resp_val_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                val_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= IDLE;
            owner_q        <= OWN_IFU;
            last_owner_q   <= OWN_LSU;
            cnt_q          <= 16'd0;
            val_q          <= 1'b0;
            rqtype_q       <= 5'd0;
            size_q         <= 3'd0;
            addr_q         <= 40'd0;
            data_q         <= 64'd0;
            ifu_req_ack_q  <= 1'b0;
            lsu_req_ack_q  <= 1'b0;
            ifu_resp_val_q <= 1'b0;
            lsu_resp_val_q <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_data0_q   <= 64'd0;
            resp_data1_q   <= 64'd0;
            req_ack_q      <= 1'b0;
            int_pulse_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_owner_q   <= last_owner_d;
            cnt_q          <= cnt_d;
            val_q          <= val_d;
            rqtype_q       <= rqtype_d;
            size_q         <= size_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            ifu_req_ack_q  <= ifu_req_ack_d;
            lsu_req_ack_q  <= lsu_req_ack_d;
            ifu_resp_val_q <= ifu_resp_val_d;
            lsu_resp_val_q <= lsu_resp_val_d;
            resp_err_q     <= resp_err_d;
            resp_data0_q   <= resp_data0_d;
            resp_data1_q   <= resp_data1_d;
            req_ack_q      <= req_ack_d;
            int_pulse_q    <= int_pulse_d;
        end
    end

    assign ifu_req_ack            = ifu_req_ack_q;
    assign lsu_req_ack            = lsu_req_ack_q;
    assign ifu_resp_val           = ifu_resp_val_q;
    assign lsu_resp_val           = lsu_resp_val_q;
    assign resp_err               = resp_err_q;
    assign resp_data0             = resp_data0_q;
    assign resp_data1             = resp_data1_q;
    assign int_ret_pulse          = int_pulse_q;
    assign transducer_l15_val     = val_q;
    assign transducer_l15_rqtype  = rqtype_q;
    assign transducer_l15_size    = size_q;
    assign transducer_l15_address = addr_q;
    assign transducer_l15_data    = data_q;
    assign transducer_l15_req_ack = req_ack_q;

endmodule

// File: tb/tb_l15_transducer_arbiter.sv
// tb_l15_transducer_arbiter
// Directed vector table for arbitration, routing, error typing and interrupt
// filtering, followed by hand-written timeout and mid-request reset sequences.
module tb_l15_transducer_arbiter;

    localparam logic [39:0] IFU_ADDR = 40'h00_8000_0040;
    localparam logic [39:0] LSU_ADDR = 40'h12_3456_7890;
    localparam logic [63:0] LSU_DATA = 64'h1234;
    localparam logic [2:0]  LSU_SIZE = 3'b011;

    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_IACK = 7'b1000000;
    localparam logic [6:0] F_LACK = 7'b0100000;
    localparam logic [6:0] F_IRSP = 7'b0010000;
    localparam logic [6:0] F_LRSP = 7'b0001000;
    localparam logic [6:0] F_ERR  = 7'b0000100;
    localparam logic [6:0] F_RACK = 7'b0000010;
    localparam logic [6:0] F_INT  = 7'b0000001;

    typedef struct {
        logic        ifu;
        logic        lsu;
        logic [4:0]  lsuType;
        logic        ack;
        logic        retVal;
        logic [3:0]  retType;
        logic [63:0] data0;
        logic        eVal;
        logic [4:0]  eRq;
        logic [6:0]  eFlags;
        logic [63:0] eData0;
    } vec_t;

    logic        clk;
    logic        nrst;
    logic        ifu_req_val;
    logic [39:0] ifu_req_addr;
    logic        lsu_req_val;
    logic [4:0]  lsu_req_rqtype;
    logic [2:0]  lsu_req_size;
    logic [39:0] lsu_req_addr;
    logic [63:0] lsu_req_data;
    logic        ifu_req_ack;
    logic        lsu_req_ack;
    logic        ifu_resp_val;
    logic        lsu_resp_val;
    logic        resp_err;
    logic [63:0] resp_data0;
    logic [63:0] resp_data1;
    logic        int_ret_pulse;
    logic        transducer_l15_val;
    logic [4:0]  transducer_l15_rqtype;
    logic [2:0]  transducer_l15_size;
    logic [39:0] transducer_l15_address;
    logic [63:0] transducer_l15_data;
    logic        transducer_l15_req_ack;
    logic        l15_transducer_ack;
    logic        l15_transducer_header_ack;
    logic        l15_transducer_val;
    logic [3:0]  l15_transducer_returntype;
    logic [63:0] l15_transducer_data_0;
    logic [63:0] l15_transducer_data_1;

    int   vecCount  = 0;
    int   missCount = 0;
    vec_t vecs[$];

    l15_transducer_arbiter #(
        .TIMEOUT_CYCLES (8),
        .INT_RET_TYPE   (4'b0111)
    ) dut (
        .clk                       (clk),
        .nrst                      (nrst),
        .ifu_req_val               (ifu_req_val),
        .ifu_req_addr              (ifu_req_addr),
        .lsu_req_val               (lsu_req_val),
        .lsu_req_rqtype            (lsu_req_rqtype),
        .lsu_req_size              (lsu_req_size),
        .lsu_req_addr              (lsu_req_addr),
        .lsu_req_data              (lsu_req_data),
        .ifu_req_ack               (ifu_req_ack),
        .lsu_req_ack               (lsu_req_ack),
        .ifu_resp_val              (ifu_resp_val),
        .lsu_resp_val              (lsu_resp_val),
        .resp_err                  (resp_err),
        .resp_data0                (resp_data0),
        .resp_data1                (resp_data1),
        .int_ret_pulse             (int_ret_pulse),
        .transducer_l15_val        (transducer_l15_val),
        .transducer_l15_rqtype     (transducer_l15_rqtype),
        .transducer_l15_size       (transducer_l15_size),
        .transducer_l15_address    (transducer_l15_address),
        .transducer_l15_data       (transducer_l15_data),
        .transducer_l15_req_ack    (transducer_l15_req_ack),
        .l15_transducer_ack        (l15_transducer_ack),
        .l15_transducer_header_ack (l15_transducer_header_ack),
        .l15_transducer_val        (l15_transducer_val),
        .l15_transducer_returntype (l15_transducer_returntype),
        .l15_transducer_data_0     (l15_transducer_data_0),
        .l15_transducer_data_1     (l15_transducer_data_1)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a sequence never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required: normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic ifu, input logic lsu, input logic [4:0] lsuType,
                          input logic ack, input logic retVal, input logic [3:0] retType,
                          input logic [63:0] data0, input logic eVal, input logic [4:0] eRq,
                          input logic [6:0] eFlags, input logic [63:0] eData0);
        vec_t v;
        v.ifu = ifu; v.lsu = lsu; v.lsuType = lsuType; v.ack = ack;
        v.retVal = retVal; v.retType = retType; v.data0 = data0;
        v.eVal = eVal; v.eRq = eRq; v.eFlags = eFlags; v.eData0 = eData0;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        ifu_req_val               = v.ifu;
        lsu_req_val               = v.lsu;
        lsu_req_rqtype            = v.lsuType;
        l15_transducer_ack        = v.ack;
        l15_transducer_val        = v.retVal;
        l15_transducer_returntype = v.retType;
        l15_transducer_data_0     = v.data0;
        l15_transducer_data_1     = ~v.data0;
    endtask

    task automatic idleInputs();
        ifu_req_val        = 1'b0;
        lsu_req_val        = 1'b0;
        lsu_req_rqtype     = 5'b00000;
        l15_transducer_ack = 1'b0;
        l15_transducer_val = 1'b0;
        l15_transducer_returntype = 4'b0000;
        l15_transducer_data_0 = 64'd0;
        l15_transducer_data_1 = 64'd0;
    endtask

    function automatic logic [6:0] packFlags();
        return {ifu_req_ack, lsu_req_ack, ifu_resp_val, lsu_resp_val,
                resp_err, transducer_l15_req_ack, int_ret_pulse};
    endfunction

    initial begin
        int respAt;
        logic sawAck;
        logic errSeen;
        logic [63:0] dataSeen;
        bit isIfu;

        nrst                      = 1'b0;
        ifu_req_addr              = IFU_ADDR;
        lsu_req_addr              = LSU_ADDR;
        lsu_req_size              = LSU_SIZE;
        lsu_req_data              = LSU_DATA;
        l15_transducer_header_ack = 1'b0;
        idleInputs();

        // Round-robin with both requesters always asking: IFU, LSU, IFU, LSU.
        addVec(1,1,5'b00000, 0,0,4'b0000, 64'h0,           1,5'b10000, F_NONE, 64'h0);
        addVec(1,1,5'b00000, 1,0,4'b0000, 64'h0,           0,5'b00000, F_IACK, 64'h0);
        addVec(1,1,5'b00000, 0,1,4'b0001, 64'hDEAD_BEEF,   0,5'b00000, F_IRSP|F_RACK, 64'hDEAD_BEEF);
        addVec(1,1,5'b00000, 0,1,4'b0001, 64'hDEAD_BEEF,   0,5'b00000, F_NONE, 64'h0);
        addVec(1,1,5'b00000, 0,0,4'b0000, 64'h0,           1,5'b00000, F_NONE, 64'h0);
        addVec(1,1,5'b00000, 0,0,4'b0000, 64'h0,           1,5'b00000, F_NONE, 64'h0);
        addVec(1,1,5'b00000, 1,0,4'b0000, 64'h0,           0,5'b00000, F_LACK, 64'h0);
        addVec(1,1,5'b00000, 0,1,4'b0000, 64'h1111,        0,5'b00000, F_LRSP|F_RACK, 64'h1111);
        addVec(1,1,5'b00000, 0,0,4'b0000, 64'h0,           0,5'b00000, F_NONE, 64'h0);
        addVec(1,1,5'b00000, 0,0,4'b0000, 64'h0,           1,5'b10000, F_NONE, 64'h0);
        addVec(1,1,5'b00000, 1,0,4'b0000, 64'h0,           0,5'b00000, F_IACK, 64'h0);
        addVec(1,1,5'b00000, 0,1,4'b0001, 64'h2222,        0,5'b00000, F_IRSP|F_RACK, 64'h2222);
        addVec(1,1,5'b00000, 0,0,4'b0000, 64'h0,           0,5'b00000, F_NONE, 64'h0);
        addVec(1,1,5'b00000, 0,0,4'b0000, 64'h0,           1,5'b00000, F_NONE, 64'h0);
        addVec(1,1,5'b00000, 1,0,4'b0000, 64'h0,           0,5'b00000, F_LACK, 64'h0);
        addVec(0,0,5'b00000, 0,1,4'b0000, 64'h3333,        0,5'b00000, F_LRSP|F_RACK, 64'h3333);
        addVec(0,0,5'b00000, 0,0,4'b0000, 64'h0,           0,5'b00000, F_NONE, 64'h0);
        // LSU store answered with a load returntype: error.
        addVec(0,1,5'b00001, 0,0,4'b0000, 64'h0,           1,5'b00001, F_NONE, 64'h0);
        addVec(0,1,5'b00001, 1,0,4'b0000, 64'h0,           0,5'b00000, F_LACK, 64'h0);
        addVec(0,0,5'b00001, 0,1,4'b0000, 64'h4444,        0,5'b00000, F_LRSP|F_ERR|F_RACK, 64'h4444);
        addVec(0,0,5'b00000, 0,0,4'b0000, 64'h0,           0,5'b00000, F_NONE, 64'h0);
        // LSU store answered with a store ack: no error.
        addVec(0,1,5'b00001, 0,0,4'b0000, 64'h0,           1,5'b00001, F_NONE, 64'h0);
        addVec(0,1,5'b00001, 1,0,4'b0000, 64'h0,           0,5'b00000, F_LACK, 64'h0);
        addVec(0,0,5'b00001, 0,1,4'b0100, 64'h6666,        0,5'b00000, F_LRSP|F_RACK, 64'h6666);
        addVec(0,0,5'b00000, 0,0,4'b0000, 64'h0,           0,5'b00000, F_NONE, 64'h0);
        // Interrupt return (held two cycles) during WAIT_RESP, then the load return.
        addVec(0,1,5'b00000, 0,0,4'b0000, 64'h0,           1,5'b00000, F_NONE, 64'h0);
        addVec(0,1,5'b00000, 1,0,4'b0000, 64'h0,           0,5'b00000, F_LACK, 64'h0);
        addVec(0,0,5'b00000, 0,1,4'b0111, 64'h0,           0,5'b00000, F_RACK|F_INT, 64'h0);
        addVec(0,0,5'b00000, 0,1,4'b0111, 64'h0,           0,5'b00000, F_NONE, 64'h0);
        addVec(0,0,5'b00000, 0,1,4'b0000, 64'h5555,        0,5'b00000, F_LRSP|F_RACK, 64'h5555);
        addVec(0,0,5'b00000, 0,0,4'b0000, 64'h0,           0,5'b00000, F_NONE, 64'h0);
        // Interrupt return while idle.
        addVec(0,0,5'b00000, 0,1,4'b0111, 64'h0,           0,5'b00000, F_RACK|F_INT, 64'h0);
        addVec(0,0,5'b00000, 0,0,4'b0000, 64'h0,           0,5'b00000, F_NONE, 64'h0);
        // IFU fill answered with the wrong returntype: error.
        addVec(1,0,5'b00000, 0,0,4'b0000, 64'h0,           1,5'b10000, F_NONE, 64'h0);
        addVec(1,0,5'b00000, 1,0,4'b0000, 64'h0,           0,5'b00000, F_IACK, 64'h0);
        addVec(0,0,5'b00000, 0,1,4'b0100, 64'h7777,        0,5'b00000, F_IRSP|F_ERR|F_RACK, 64'h7777);
        addVec(0,0,5'b00000, 0,0,4'b0000, 64'h0,           0,5'b00000, F_NONE, 64'h0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_flags", 64'(packFlags()), 64'h0);
        checkOutput("reset_val", 64'(transducer_l15_val), 64'h0);
        checkOutput("reset_data0", resp_data0, 64'h0);
        @(negedge clk);
        nrst = 1'b1;

        // Table-driven vectors: drive, clock, sample 1 unit after the edge.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_flags", i), 64'(packFlags()), 64'(vecs[i].eFlags));
            checkOutput($sformatf("vec%0d_val", i), 64'(transducer_l15_val), 64'(vecs[i].eVal));
            if (vecs[i].eVal) begin
                isIfu = (vecs[i].eRq == 5'b10000);
                checkOutput($sformatf("vec%0d_rqtype", i), 64'(transducer_l15_rqtype), 64'(vecs[i].eRq));
                checkOutput($sformatf("vec%0d_addr", i), 64'(transducer_l15_address),
                            64'(isIfu ? IFU_ADDR : LSU_ADDR));
                checkOutput($sformatf("vec%0d_size", i), 64'(transducer_l15_size),
                            64'(isIfu ? 3'b111 : LSU_SIZE));
                checkOutput($sformatf("vec%0d_sdata", i), transducer_l15_data,
                            isIfu ? 64'h0 : LSU_DATA);
            end
            if ((vecs[i].eFlags & (F_IRSP | F_LRSP)) != 7'd0) begin
                checkOutput($sformatf("vec%0d_rdata0", i), resp_data0, vecs[i].eData0);
                checkOutput($sformatf("vec%0d_rdata1", i), resp_data1, ~vecs[i].eData0);
            end
        end

        // Timeout: LSU load with no return; error response 8 cycles into WAIT_RESP.
        idleInputs();
        lsu_req_val = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("to_req_val", 64'(transducer_l15_val), 64'h1);
        l15_transducer_ack = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("to_lsu_ack", 64'(lsu_req_ack), 64'h1);
        idleInputs();
        respAt   = -1;
        sawAck   = 1'b0;
        errSeen  = 1'b0;
        dataSeen = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (transducer_l15_req_ack) sawAck = 1'b1;
            if (lsu_resp_val) begin
                respAt   = k;
                errSeen  = resp_err;
                dataSeen = resp_data0;
                break;
            end
        end
        checkOutput("to_latency", 64'(respAt), 64'd8);
        checkOutput("to_err", 64'(errSeen), 64'h1);
        checkOutput("to_data0", dataSeen, 64'h0);
        checkOutput("to_no_req_ack", 64'(sawAck), 64'h0);
        @(posedge clk);
        #1;

        // Reset in REQ: val drops without a clock edge, then IFU wins the tie.
        lsu_req_val = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_pre_val", 64'(transducer_l15_val), 64'h1);
        checkOutput("rst_pre_rqtype", 64'(transducer_l15_rqtype), 64'h0);
        #2;
        nrst = 1'b0;
        #1;
        checkOutput("rst_async_val", 64'(transducer_l15_val), 64'h0);
        @(negedge clk);
        nrst = 1'b1;
        ifu_req_val = 1'b1;
        lsu_req_val = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_tie_val", 64'(transducer_l15_val), 64'h1);
        checkOutput("rst_tie_rqtype", 64'(transducer_l15_rqtype), 64'h10);
        checkOutput("rst_no_ack", 64'(packFlags()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
